// File: rtl/vend_panel_arbiter.sv
// ----------------------------------------------------------------------------
// vend_panel_arbiter
//
// Purpose:
//   Shares one vending_machine core between two customer panels (A and B).
//   A round-robin arbiter grants one panel a sticky session. While the session
//   is open, that panel's coins are registered onto the core's coin input. The
//   core's dispense/change result is routed back to the granted panel only.
//   Each session closes through a single DONE cycle.
//
// Optional feature (macro VEND_ARB_TIMEOUT_EN):
//   When defined, an idle counter aborts a granted session after TIMEOUT
//   cycles without a coin and pulses timeout_err. When undefined, no counter
//   is built and timeout_err is tied low.
//
// Ports:
//   clk                 in   rising-edge clock
//   rst                 in   asynchronous active-low reset
//   req_a / req_b       in   panel session requests
//   coin_a / coin_b     in   [1:0] panel coin codes (00 none, 01 five,
//                            10 ten, 11 illegal)
//   vm_in               out  [1:0] coin code forwarded to the core
//   vm_out              in   dispense pulse from the core
//   vm_change           in   [1:0] change code from the core (00 = none)
//   gnt_a / gnt_b       out  session grant per panel
//   out_a / out_b       out  dispense routed to the granted panel
//   change_a / change_b out  [1:0] change routed to the granted panel
//   busy                out  high whenever the arbiter is not IDLE
//   timeout_err         out  one-cycle pulse when a session is aborted
// ----------------------------------------------------------------------------
module vend_panel_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [1:0] coin_a,
    input  logic [1:0] coin_b,
    output logic [1:0] vm_in,
    input  logic       vm_out,
    input  logic [1:0] vm_change,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       out_a,
    output logic       out_b,
    output logic [1:0] change_a,
    output logic [1:0] change_b,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_prio_b;      // 1: B wins the next contention, 0: A wins
    logic [1:0] r_vm_in;
    logic       r_out_a;
    logic       r_out_b;
    logic [1:0] r_change_a;
    logic [1:0] r_change_b;
    logic       w_result;

    // A result from the core is either a dispense pulse or any change code.
    assign w_result = vm_out | (|vm_change);

`ifdef VEND_ARB_TIMEOUT_EN
    localparam logic [3:0] LP_LAST_IDLE = 4'(TIMEOUT - 1);

    logic [3:0] r_idle_cnt;
    logic       r_timeout_err;
    logic       w_timeout;
`else
    logic [3:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT[3:0];
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
`ifdef VEND_ARB_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (req_a && req_b) begin
                    w_next = r_prio_b ? GRANT_B : GRANT_A;
                end else if (req_a) begin
                    w_next = GRANT_A;
                end else if (req_b) begin
                    w_next = GRANT_B;
                end
            end
            GRANT_A: begin
                if (w_result) begin
                    w_next = DONE;
`ifdef VEND_ARB_TIMEOUT_EN
                // A coin on the final idle cycle still keeps the session alive.
                end else if (r_idle_cnt == LP_LAST_IDLE && coin_a == 2'b00) begin
                    w_next    = DONE;
                    w_timeout = 1'b1;
`endif
                end
            end
            GRANT_B: begin
                if (w_result) begin
                    w_next = DONE;
`ifdef VEND_ARB_TIMEOUT_EN
                end else if (r_idle_cnt == LP_LAST_IDLE && coin_b == 2'b00) begin
                    w_next    = DONE;
                    w_timeout = 1'b1;
`endif
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        gnt_a = (r_state == GRANT_A);
        gnt_b = (r_state == GRANT_B);
        busy  = (r_state != IDLE);
    end

    // Registered datapath: coin forwarding, result routing, round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vm_in    <= 2'b00;
            r_out_a    <= 1'b0;
            r_out_b    <= 1'b0;
            r_change_a <= 2'b00;
            r_change_b <= 2'b00;
            r_prio_b   <= 1'b0;
        end else begin
            // Coins only pass while the session continues, so DONE always
            // presents 00 to the core; illegal code 11 is squashed to 00.
            r_vm_in <= 2'b00;
            if (r_state == GRANT_A && w_next == GRANT_A && coin_a != 2'b11) begin
                r_vm_in <= coin_a;
            end else if (r_state == GRANT_B && w_next == GRANT_B && coin_b != 2'b11) begin
                r_vm_in <= coin_b;
            end

            // Results are honoured only inside a grant; in IDLE/DONE they drop.
            r_out_a    <= (r_state == GRANT_A) & vm_out;
            r_out_b    <= (r_state == GRANT_B) & vm_out;
            r_change_a <= (r_state == GRANT_A) ? vm_change : 2'b00;
            r_change_b <= (r_state == GRANT_B) ? vm_change : 2'b00;

            if (r_state == IDLE && w_next == GRANT_A) begin
                r_prio_b <= 1'b1;
            end else if (r_state == IDLE && w_next == GRANT_B) begin
                r_prio_b <= 1'b0;
            end
        end
    end

`ifdef VEND_ARB_TIMEOUT_EN
    // Idle counter: value k during the k-th cycle after entering a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle_cnt    <= 4'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state == IDLE) begin
                r_idle_cnt <= 4'd0;
            end else if (r_state == GRANT_A && coin_a != 2'b00) begin
                r_idle_cnt <= 4'd0;
            end else if (r_state == GRANT_B && coin_b != 2'b00) begin
                r_idle_cnt <= 4'd0;
            end else if (r_state == GRANT_A || r_state == GRANT_B) begin
                r_idle_cnt <= r_idle_cnt + 4'd1;
            end else begin
                r_idle_cnt <= 4'd0;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    assign vm_in    = r_vm_in;
    assign out_a    = r_out_a;
    assign out_b    = r_out_b;
    assign change_a = r_change_a;
    assign change_b = r_change_b;

endmodule

// File: doc/vend_panel_arbiter.md
VEND_PANEL_ARBITER -- requirements
Module: vend_panel_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: idle cycles in a granted session before abort (4-bit counter range, 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_a / req_b  input  1 each  panel A / panel B requests a vending session.
REQ-005 coin_a / coin_b  input  2 each  coin code per panel: 00 none, 01 five, 10 ten, 11 illegal.
REQ-006 vm_in  output  2  coin code forwarded to the shared vending_machine core.
REQ-007 vm_out  input  1  dispense pulse from the core.
REQ-008 vm_change  input  2  change code from the core; 00 means no change.
REQ-009 gnt_a / gnt_b  output  1 each  session grant per panel; never both high.
REQ-010 out_a / out_b  output  1 each  dispense routed to the granted panel.
REQ-011 change_a / change_b  output  2 each  change routed to the granted panel.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 timeout_err  output  1  one-cycle pulse on session abort (macro-dependent, REQ-030).

Function
REQ-014 The FSM SHALL have states IDLE, GRANT_A, GRANT_B and DONE.
REQ-015 IDLE: one request -> that panel's GRANT state on the next edge; no request -> stay.
REQ-016 Simultaneous req_a and req_b in IDLE SHALL grant the panel not served last (round-robin pointer).
REQ-017 The round-robin pointer SHALL update on every grant; after reset it favours A.
REQ-018 gnt_x SHALL be registered, high exactly while in GRANT_x.
REQ-019 In GRANT_x, coin_x SHALL be registered onto vm_in with 1-cycle latency; the other panel's coins are dropped.
REQ-020 Code 11 and any coin outside a grant SHALL be forwarded as 00.
REQ-021 A granted session SHALL be sticky: deasserting req_x mid-session does not end it.
REQ-022 In GRANT_x, vm_out=1 or vm_change!=00 sampled at an edge SHALL end the session -> DONE.
REQ-023 The sampled vm_out/vm_change SHALL appear on out_x/change_x for exactly one cycle, one cycle after sampling; the other panel's outputs stay 0.
REQ-024 vm_out and vm_change arriving in the same cycle SHALL both be routed in that same output cycle.
REQ-025 vm_out/vm_change while in IDLE or DONE SHALL be ignored.
REQ-026 DONE SHALL last exactly one cycle with vm_in=00, then IDLE; re-arbitration starts in IDLE.
REQ-027 Shortest session is grant, coin, result, DONE: a panel's next grant comes no earlier than 2 cycles after its previous session ends.

Reset
REQ-028 rst low SHALL immediately force IDLE and set gnt_a, gnt_b, out_a, out_b, busy, timeout_err to 0; vm_in, change_a, change_b to 00; pointer to favour A; timeout counter to 0.
REQ-029 Reset asserted mid-session SHALL abandon the session with no routed output; operation resumes on the first clk edge after rst goes high.

Configuration
REQ-030 Macro VEND_ARB_TIMEOUT_EN defined: an idle counter clears on each non-00 coin_x in GRANT_x and on entry to GRANT_x, and on reaching TIMEOUT forces DONE with a one-cycle timeout_err pulse.
REQ-031 VEND_ARB_TIMEOUT_EN undefined: no counter is built, sessions never abort, and timeout_err is tied to 0.

Verification
REQ-032 Single A: req_a=1, coin_a=10 for one cycle, then vm_out=1 and vm_change=00 -> gnt_a high one cycle after req, vm_in=10 one cycle after the coin, out_a=1 for one cycle, then DONE -> IDLE, gnt_b=0 throughout.
REQ-033 Contention: req_a=req_b=1 after reset -> A granted; after A's session with both requests still high -> B granted; next contention -> A.
REQ-034 Isolation: in GRANT_A, coin_b=10 and coin_a=11 -> vm_in stays 00; vm_change=01 -> change_a=01, change_b=00.
REQ-035 Reset mid-session: in GRANT_B, pull rst low between edges -> gnt_b, busy and vm_in go 0 immediately; after release with no requests, the block stays in IDLE.
REQ-036 Timeout (macro on, TIMEOUT=15): grant A, no coins -> timeout_err pulses and gnt_a drops 15 cycles after grant; macro off -> gnt_a held for 40 cycles.
